alu_share_arbiter: RTL and testbench

//  Shares the single 32-bit alu instance between two requesters: req0 = CPU execute stage
//  (priority) and req1 = checkers move-generator engine (sur/sul/sura/sula board-mask work).

---
 rtl/alu_share_arbiter_pkg.sv | 45 ++++
 rtl/alu.sv | 47 ++++
 rtl/alu_grant_ctrl.sv | 36 +++
 rtl/alu_share_arbiter.sv | 97 +++++++++
 tb/tb_alu_share_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared alu opcode encodings, requester tags and pipeline payload types for the
// alu sharing arbiter, decoder and move generator.
package alu_share_arbiter_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SRA  = 5'b00101;
  localparam logic [4:0] OP_SUR  = 5'b00110;
  localparam logic [4:0] OP_SUL  = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_SURA = 5'b10110;
  localparam logic [4:0] OP_SULA = 5'b10111;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_MG  = 1'b1;

  typedef struct packed {
    logic        id;
    logic [4:0]  opcode;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        ne;
    logic        lt;
    logic        ovf;
  } alu_rsp_t;

  // Board-mask diagonal moves on the 32-square bitboard: up-right and up-left.
  function automatic logic [31:0] sur(input logic [31:0] m);
    return m << 4;
  endfunction

  function automatic logic [31:0] sul(input logic [31:0] m);
    return m << 5;
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit alu. Flags come from the adder, which subtracts for every
// opcode except ADD so ne/lt read as an A-vs-B compare outside of ADD.
module alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow
);

  logic        is_add;
  logic [31:0] b_eff;
  logic [31:0] sum;
  logic        ovf_raw;
  logic [4:0]  op_n;

  always_comb begin
    is_add     = (ctrl_ALUopcode == OP_ADD);
    b_eff      = is_add ? data_operandB : ~data_operandB;
    sum        = data_operandA + b_eff + {31'd0, ~is_add};
    ovf_raw    = (data_operandA[31] == b_eff[31]) & (sum[31] != data_operandA[31]);
    isNotEqual = |sum;
    isLessThan = sum[31] ^ ovf_raw;
    overflow   = ovf_raw & (is_add | (ctrl_ALUopcode == OP_SUB));
    // sura/sula ignore bit 3 of the opcode
    op_n       = ctrl_ALUopcode[4] ? (ctrl_ALUopcode & 5'b10111) : ctrl_ALUopcode;
    case (op_n)
      OP_ADD, OP_SUB: data_result = sum;
      OP_AND:         data_result = data_operandA & data_operandB;
      OP_OR:          data_result = data_operandA | data_operandB;
      OP_SLL:         data_result = data_operandA << ctrl_shiftamt;
      OP_SRA:         data_result = 32'($signed(data_operandA) >>> ctrl_shiftamt);
      OP_SUR:         data_result = sur(data_operandA);
      OP_SUL:         data_result = sul(data_operandA);
      OP_NOT:         data_result = ~data_operandA;
      OP_SURA:        data_result = data_operandA & sur(data_operandB);
      OP_SULA:        data_result = data_operandA & sul(data_operandB);
      default:        data_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_grant_ctrl.sv
// Fixed-priority grant (CPU first) with a saturating starvation counter that
// force-grants the move generator after STARVE_LIMIT stalled cycles.
module alu_grant_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic r0_valid,
  input  logic r1_valid,
  output logic r0_ready,
  output logic r1_ready
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          force1;

  always_comb begin
    force1       = (STARVE_LIMIT != 0) && (starve_cnt_q == LIM) && r1_valid;
    r0_ready     = ~force1;
    r1_ready     = force1 | ~r0_valid;
    starve_cnt_d = starve_cnt_q;
    if (r1_valid && r1_ready)
      starve_cnt_d = '0;
    else if (r1_valid && (starve_cnt_q != LIM))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared alu: grant, S1 operand stage, alu, and a
// registered tagged response stage. Latency 2, one op per cycle.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [4:0]  r0_opcode,
  input  logic [4:0]  r0_shamt,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [4:0]  r1_opcode,
  input  logic [4:0]  r1_shamt,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic        flush,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_ne,
  output logic        rsp_lt,
  output logic        rsp_ovf
);

  logic     hs0, hs1;
  logic     s1_valid_q, s1_valid_d;
  alu_req_t s1_q, s1_d;
  logic     rsp_valid_q, rsp_valid_d;
  alu_rsp_t rsp_q, rsp_d;

  logic [31:0] alu_res;
  logic        alu_ne, alu_lt, alu_ovf;

  alu_grant_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clock    (clock),
    .reset    (reset),
    .r0_valid (r0_valid),
    .r1_valid (r1_valid),
    .r0_ready (r0_ready),
    .r1_ready (r1_ready)
  );

  alu u_alu (
    .data_operandA  (s1_q.a),
    .data_operandB  (s1_q.b),
    .ctrl_ALUopcode (s1_q.opcode),
    .ctrl_shiftamt  (s1_q.shamt),
    .data_result    (alu_res),
    .isNotEqual     (alu_ne),
    .isLessThan     (alu_lt),
    .overflow       (alu_ovf)
  );

  always_comb begin
    hs0 = r0_valid & r0_ready;
    hs1 = r1_valid & r1_ready;
    // A CPU op accepted during a flush is dropped, not stalled
    s1_valid_d = hs1 | (hs0 & ~flush);
    s1_d       = s1_q;
    if (s1_valid_d) begin
      if (hs1) s1_d = '{id: REQ_MG,  opcode: r1_opcode, shamt: r1_shamt, a: r1_a, b: r1_b};
      else     s1_d = '{id: REQ_CPU, opcode: r0_opcode, shamt: r0_shamt, a: r0_a, b: r0_b};
    end
    rsp_valid_d = s1_valid_q & ~(flush & (s1_q.id == REQ_CPU));
    rsp_d       = rsp_q;
    if (rsp_valid_d)
      rsp_d = '{id: s1_q.id, result: alu_res, ne: alu_ne, lt: alu_lt, ovf: alu_ovf};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_ne     = rsp_q.ne;
  assign rsp_lt     = rsp_q.lt;
  assign rsp_ovf    = rsp_q.ovf;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a STARVE_LIMIT=4 instance and a pure-priority
// instance share stimulus; expected values are hand-computed constants.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r0_valid, r1_valid, flush;
  logic [4:0]  r0_opcode, r0_shamt, r1_opcode, r1_shamt;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;

  logic        r0_ready, r1_ready, rsp_valid, rsp_id, rsp_ne, rsp_lt, rsp_ovf;
  logic [31:0] rsp_result;
  logic        n_r0_ready, n_r1_ready, n_rsp_valid, n_rsp_id, n_rsp_ne, n_rsp_lt, n_rsp_ovf;
  logic [31:0] n_rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  alu_share_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_shamt(r0_shamt),
    .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_shamt(r1_shamt),
    .r1_a(r1_a), .r1_b(r1_b),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ne(rsp_ne), .rsp_lt(rsp_lt), .rsp_ovf(rsp_ovf)
  );

  alu_share_arbiter #(.STARVE_LIMIT(0)) dut_np (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(n_r0_ready), .r0_opcode(r0_opcode), .r0_shamt(r0_shamt),
    .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(n_r1_ready), .r1_opcode(r1_opcode), .r1_shamt(r1_shamt),
    .r1_a(r1_a), .r1_b(r1_b),
    .flush(flush),
    .rsp_valid(n_rsp_valid), .rsp_id(n_rsp_id), .rsp_result(n_rsp_result),
    .rsp_ne(n_rsp_ne), .rsp_lt(n_rsp_lt), .rsp_ovf(n_rsp_ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_r0(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    r0_valid = v; r0_opcode = op; r0_shamt = 5'd0; r0_a = a; r0_b = b;
  endtask

  task automatic set_r1(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    r1_valid = v; r1_opcode = op; r1_shamt = 5'd0; r1_a = a; r1_b = b;
  endtask

  task automatic idle;
    set_r0(1'b0, OP_ADD, 32'd0, 32'd0);
    set_r1(1'b0, OP_ADD, 32'd0, 32'd0);
    flush = 1'b0;
  endtask

  // Requester rule: fields of a stalled request must not move while it stays valid
  logic        p0_stall = 1'b0, p1_stall = 1'b0;
  logic [41:0] p0_f, p1_f;
  logic [31:0] p0_b, p1_b;
  always @(posedge clock) begin
    if (p0_stall && r0_valid) begin
      chk("r0_hold", {22'd0, r0_opcode, r0_shamt, r0_a}, {22'd0, p0_f});
      chk("r0_hold_b", {32'd0, r0_b}, {32'd0, p0_b});
    end
    if (p1_stall && r1_valid) begin
      chk("r1_hold", {22'd0, r1_opcode, r1_shamt, r1_a}, {22'd0, p1_f});
      chk("r1_hold_b", {32'd0, r1_b}, {32'd0, p1_b});
    end
    p0_stall <= r0_valid & ~r0_ready & ~reset;
    p1_stall <= r1_valid & ~r1_ready & ~reset;
    p0_f <= {r0_opcode, r0_shamt, r0_a};
    p1_f <= {r1_opcode, r1_shamt, r1_a};
    p0_b <= r0_b;
    p1_b <= r1_b;
  end

  initial begin
    logic exp_id;
    idle();
    reset = 1'b1;
    tick(); tick();
    chk("rst_valid",  64'(rsp_valid), 64'd0);
    chk("rst_id",     64'(rsp_id), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_flags",  64'({rsp_ne, rsp_lt, rsp_ovf}), 64'd0);
    chk("rst_ready",  64'({r0_ready, r1_ready}), 64'b11);
    chk("rst_starve", 64'(dut.u_grant.starve_cnt_q), 64'd0);
    reset = 1'b0;

    // 1: single CPU ADD, latency 2
    set_r0(1'b1, OP_ADD, 32'd5, 32'd7);
    #1 chk("t1_r0_ready", 64'(r0_ready), 64'd1);
    tick();
    idle();
    chk("t1_lat1_valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_valid",  64'(rsp_valid), 64'd1);
    chk("t1_id",     64'(rsp_id), 64'd0);
    chk("t1_result", 64'(rsp_result), 64'd12);
    chk("t1_flags",  64'({rsp_ne, rsp_lt, rsp_ovf}), 64'b100);
    tick();
    chk("t1_done_valid", 64'(rsp_valid), 64'd0);
    chk("t1_sticky",     64'(rsp_result), 64'd12);

    // 2 (+5b): both requesters saturated for 10 cycles
    for (int i = 1; i <= 11; i++) begin
      set_r0(i <= 10, OP_ADD, 32'd1, 32'd1);
      set_r1(i <= 10, OP_OR, 32'h10, 32'h01);
      if (i <= 10) begin
        exp_id = (i == 5) || (i == 10);
        #1;
        chk($sformatf("t2_r1_ready_c%0d", i), 64'(r1_ready), 64'(exp_id));
        chk($sformatf("t2_r0_ready_c%0d", i), 64'(r0_ready), 64'(!exp_id));
        chk($sformatf("t5_np_ready_c%0d", i), 64'({n_r0_ready, n_r1_ready}), 64'b10);
      end
      tick();
      if (i >= 2) begin
        exp_id = (i - 1 == 5) || (i - 1 == 10);
        chk($sformatf("t2_valid_c%0d", i - 1), 64'(rsp_valid), 64'd1);
        chk($sformatf("t2_id_c%0d", i - 1), 64'(rsp_id), 64'(exp_id));
        chk($sformatf("t2_res_c%0d", i - 1), 64'(rsp_result), exp_id ? 64'h11 : 64'h2);
        chk($sformatf("t5_np_id_c%0d", i - 1), 64'({n_rsp_valid, n_rsp_id}), 64'b10);
      end
    end
    idle();
    tick();
    chk("t2_drain", 64'(rsp_valid), 64'd0);

    // 3: overflowing SUB, back-to-back SULA, then NOT pass-through
    set_r0(1'b1, OP_SUB, 32'h8000_0000, 32'd1);
    tick();
    idle();
    set_r1(1'b1, OP_SULA, 32'hFFFF_FFFF, 32'h0000_00F0);
    tick();
    chk("t3_sub_id",  64'({rsp_valid, rsp_id}), 64'b10);
    chk("t3_sub_res", 64'(rsp_result), 64'h7FFF_FFFF);
    chk("t3_sub_ovf", 64'(rsp_ovf), 64'd1);
    idle();
    set_r0(1'b1, OP_NOT, 32'h0F0F_0F0F, 32'd0);
    tick();
    chk("t3_sula_id",  64'({rsp_valid, rsp_id}), 64'b11);
    chk("t3_sula_res", 64'(rsp_result), 64'h0000_1E00);
    idle();
    tick();
    chk("t3_not_id",  64'({rsp_valid, rsp_id}), 64'b10);
    chk("t3_not_res", 64'(rsp_result), 64'hF0F0_F0F0);
    tick();
    chk("t3_drain", 64'(rsp_valid), 64'd0);

    // 4a: flush kills in-flight CPU op, move-generator op behind it survives
    set_r0(1'b1, OP_ADD, 32'd2, 32'd3);
    tick();
    idle();
    set_r1(1'b1, OP_OR, 32'hF0, 32'h0F);
    flush = 1'b1;
    #1 chk("t4_r1_ready", 64'(r1_ready), 64'd1);
    tick();
    chk("t4_killed", 64'(rsp_valid), 64'd0);
    idle();
    tick();
    chk("t4_mg_id",  64'({rsp_valid, rsp_id}), 64'b11);
    chk("t4_mg_res", 64'(rsp_result), 64'hFF);
    tick();
    chk("t4_drain", 64'(rsp_valid), 64'd0);

    // 4b: CPU op accepted in the flush cycle is dropped
    set_r0(1'b1, OP_ADD, 32'd1, 32'd1);
    flush = 1'b1;
    #1 chk("t4b_r0_ready", 64'(r0_ready), 64'd1);
    tick();
    idle();
    chk("t4b_none1", 64'(rsp_valid), 64'd0);
    tick();
    chk("t4b_none2", 64'(rsp_valid), 64'd0);

    // 4c: CPU response already on the bus is still delivered during a flush
    set_r0(1'b1, OP_ADD, 32'd4, 32'd4);
    tick();
    idle();
    tick();
    flush = 1'b1;
    #1;
    chk("t4c_valid", 64'({rsp_valid, rsp_id}), 64'b10);
    chk("t4c_res",   64'(rsp_result), 64'd8);
    tick();
    flush = 1'b0;
    chk("t4c_drain", 64'(rsp_valid), 64'd0);

    // 5: reset with S1 and rsp both occupied and the starve counter mid-count
    set_r0(1'b1, OP_ADD, 32'd9, 32'd1);
    set_r1(1'b1, OP_OR, 32'd3, 32'd4);
    tick(); tick(); tick();
    chk("t5_pre_valid",  64'(rsp_valid), 64'd1);
    chk("t5_pre_starve", 64'(dut.u_grant.starve_cnt_q), 64'd3);
    idle();
    reset = 1'b1;
    tick();
    chk("t5_rst_valid",  64'(rsp_valid), 64'd0);
    chk("t5_rst_result", 64'(rsp_result), 64'd0);
    chk("t5_rst_starve", 64'(dut.u_grant.starve_cnt_q), 64'd0);
    chk("t5_rst_ready",  64'({r0_ready, r1_ready}), 64'b11);
    reset = 1'b0;
    set_r0(1'b1, OP_ADD, 32'd9, 32'd1);
    set_r1(1'b1, OP_OR, 32'd3, 32'd4);
    #1 chk("t5_no_force", 64'({r0_ready, r1_ready}), 64'b10);
    idle();
    tick();
    chk("t5_post_valid", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
